// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive deframer: FSM states,
// character-length and parity encodings, and small decode helpers.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam logic [1:0] LEN_5 = 2'b00;
  localparam logic [1:0] LEN_6 = 2'b01;
  localparam logic [1:0] LEN_7 = 2'b10;
  localparam logic [1:0] LEN_8 = 2'b11;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;
  localparam logic [1:0] PAR_RSVD = 2'b11;

  localparam int         OVERSAMPLE = 16;
  localparam logic [3:0] MID_SAMPLE = 4'd7;

  function automatic logic [3:0] data_bits(input logic [1:0] len);
    case (len)
      LEN_5:   return 4'd5;
      LEN_6:   return 4'd6;
      LEN_7:   return 4'd7;
      LEN_8:   return 4'd8;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic [7:0] data_mask(input logic [1:0] len);
    case (len)
      LEN_5:   return 8'h1F;
      LEN_6:   return 8'h3F;
      LEN_7:   return 8'h7F;
      LEN_8:   return 8'hFF;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic parity_enabled(input logic [1:0] parity_type);
    case (parity_type)
      PAR_ODD, PAR_EVEN:  return 1'b1;
      PAR_NONE, PAR_RSVD: return 1'b0;
      default:            return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Metastability synchroniser for the serial line plus a tick-rate falling
// edge detector used to arm start-bit detection.
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic baud_tick,
  input  logic rx_in,
  output logic rxs,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   prev;

  // prev advances at the tick rate so a fall stays visible until the next tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_chain <= '1;
      prev       <= 1'b1;
    end else begin
      sync_chain <= {sync_chain[SYNC_STAGES-2:0], rx_in};
      if (baud_tick) prev <= sync_chain[SYNC_STAGES-1];
    end
  end

  assign rxs  = sync_chain[SYNC_STAGES-1];
  assign fall = prev & ~rxs;

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receiver: 16x oversampled start detect, mid-bit sampling, LSB-first
// deframing with parity and stop checks, one-clock valid per frame.
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = uart_pkg::OVERSAMPLE,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_tick,
  input  logic       rx_in,
  input  logic [1:0] len,
  input  logic [1:0] parity_type,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       rx_active
);

  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);

  logic       rxs;
  logic       fall;

  rx_state_e  state;
  logic [3:0] tick_cnt;
  logic [2:0] bit_idx;
  logic [7:0] shift_reg;
  logic [1:0] cfg_len;
  logic [1:0] cfg_par;
  logic       par_err_r;

  logic [2:0] last_idx;
  logic [7:0] cfg_mask;
  logic       cfg_par_en;
  logic       par_expected;

  uart_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .baud_tick(baud_tick),
    .rx_in    (rx_in),
    .rxs      (rxs),
    .fall     (fall)
  );

  always_comb begin
    last_idx     = 3'(data_bits(cfg_len) - 4'd1);
    cfg_mask     = data_mask(cfg_len);
    cfg_par_en   = parity_enabled(cfg_par);
    par_expected = (cfg_par == PAR_ODD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tick_cnt   <= 4'd0;
      bit_idx    <= 3'd0;
      shift_reg  <= 8'd0;
      cfg_len    <= LEN_8;
      cfg_par    <= PAR_NONE;
      par_err_r  <= 1'b0;
      data_out   <= 8'd0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      rx_active  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (baud_tick) begin
        case (state)
          IDLE: begin
            if (fall) begin
              cfg_len   <= len;
              cfg_par   <= parity_type;
              tick_cnt  <= 4'd0;
              bit_idx   <= 3'd0;
              shift_reg <= 8'd0;
              par_err_r <= 1'b0;
              rx_active <= 1'b1;
              state     <= START;
            end
          end

          // a line that is high again at mid start bit was only a glitch
          START: begin
            if (tick_cnt == MID_SAMPLE) begin
              tick_cnt <= 4'd0;
              if (rxs) begin
                rx_active <= 1'b0;
                state     <= IDLE;
              end else begin
                bit_idx <= 3'd0;
                state   <= DATA;
              end
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end

          DATA: begin
            if (tick_cnt == LAST_TICK) begin
              shift_reg[bit_idx] <= rxs;
              tick_cnt           <= 4'd0;
              bit_idx            <= bit_idx + 3'd1;
              if (bit_idx == last_idx) state <= cfg_par_en ? PARITY : STOP;
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end

          PARITY: begin
            if (tick_cnt == LAST_TICK) begin
              par_err_r <= ((^(shift_reg & cfg_mask)) ^ rxs) != par_expected;
              tick_cnt  <= 4'd0;
              state     <= STOP;
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end

          // frame is delivered even when parity or stop errors are flagged
          STOP: begin
            if (tick_cnt == LAST_TICK) begin
              data_out   <= shift_reg & cfg_mask;
              parity_err <= cfg_par_en & par_err_r;
              frame_err  <= ~rxs;
              data_valid <= 1'b1;
              rx_active  <= 1'b0;
              tick_cnt   <= 4'd0;
              state      <= IDLE;
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end

          default: begin
            tick_cnt  <= 4'd0;
            rx_active <= 1'b0;
            state     <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Bench for uart_rx_deframer: drives serial frames at 16 ticks per bit and
// compares delivered bytes and error flags with a frame-level model.
module tb_uart_rx_deframer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       baud_tick = 1'b0;
  logic       rx_in = 1'b1;
  logic [1:0] len = 2'b11;
  logic [1:0] parity_type = 2'b00;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_err;
  logic       frame_err;
  logic       rx_active;

  int checks = 0;
  int errors = 0;
  int wide_cnt = 0;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } rec_t;

  rec_t rec_q[$];
  logic vld_last = 1'b0;

  uart_rx_deframer #(
    .OVERSAMPLE (16),
    .SYNC_STAGES(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .baud_tick  (baud_tick),
    .rx_in      (rx_in),
    .len        (len),
    .parity_type(parity_type),
    .data_out   (data_out),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .rx_active  (rx_active)
  );

  always #5 clk = ~clk;

  initial begin
    int c;
    c = 0;
    forever begin
      @(negedge clk);
      baud_tick = (c == 3);
      c = (c + 1) % 4;
    end
  end

  always @(negedge clk) begin
    if (data_valid) begin
      rec_q.push_back({data_out, parity_err, frame_err});
      if (vld_last) wide_cnt <= wide_cnt + 1;
    end
    vld_last <= data_valid;
  end

  initial begin
    #(1_500_000);
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic wait_tick();
    do @(posedge clk); while (!baud_tick);
  endtask

  task automatic drive(input logic v, input int nticks);
    @(negedge clk);
    rx_in = v;
    repeat (nticks) wait_tick();
  endtask

  function automatic rec_t pop_rec();
    if (rec_q.size() == 0) return 'x;
    return rec_q.pop_front();
  endfunction

  // Frame-level reference: what the receiver must report for a given frame
  function automatic rec_t model(input logic [7:0] d, input logic [1:0] l,
                                 input logic [1:0] pt, input logic pbit,
                                 input logic stop);
    int   n;
    int   ones;
    logic [7:0] m;
    rec_t r;
    n    = 5 + int'(l);
    m    = 8'((1 << n) - 1);
    ones = $countones(d & m);
    r.d  = d & m;
    r.pe = (pt == 2'b01 || pt == 2'b10) &&
           (((ones + int'(pbit)) % 2) != ((pt == 2'b01) ? 1 : 0));
    r.fe = (stop == 1'b0);
    return r;
  endfunction

  function automatic logic good_parity(input logic [7:0] d, input logic [1:0] l,
                                       input logic [1:0] pt);
    int ones;
    ones = $countones(d & 8'((1 << (5 + int'(l))) - 1));
    return (pt == 2'b01) ? ((ones % 2) == 0) : ((ones % 2) == 1);
  endfunction

  task automatic send_frame(input logic [7:0] d, input logic [1:0] l,
                            input logic [1:0] pt, input logic pbit,
                            input logic stop, input logic scramble);
    int n;
    n = 5 + int'(l);
    len = l;
    parity_type = pt;
    drive(1'b0, 16);
    if (scramble) begin
      len = 2'($urandom);
      parity_type = 2'($urandom);
    end
    for (int i = 0; i < n; i++) drive(d[i], 16);
    if (pt == 2'b01 || pt == 2'b10) drive(pbit, 16);
    drive(stop, 16);
    drive(1'b1, 2);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if ({data_out, data_valid, parity_err, frame_err, rx_active} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs got %h want 000",
               {data_out, data_valid, parity_err, frame_err, rx_active});
    end
    rst = 1'b0;
    drive(1'b1, 4);
  endtask

  task automatic test_8n1();
    rec_t r;
    rec_t e;
    send_frame(8'hA5, 2'b11, 2'b00, 1'b0, 1'b1, 1'b0);
    e = '{d: 8'hA5, pe: 1'b0, fe: 1'b0};
    checks++;
    if (rec_q.size() !== 1) begin
      errors++;
      $display("FAIL 8n1_count got %0d want 1", rec_q.size());
    end
    r = pop_rec();
    rec_q.delete();
    checks++;
    if (r !== e) begin
      errors++;
      $display("FAIL 8n1_frame got d=%h pe=%b fe=%b want d=%h pe=%b fe=%b", r.d, r.pe, r.fe, e.d, e.pe, e.fe);
    end
    checks++;
    if (wide_cnt !== 0) begin
      errors++;
      $display("FAIL 8n1_valid_width got %0d wide pulses want 0", wide_cnt);
    end
    checks++;
    if (rx_active !== 1'b0) begin
      errors++;
      $display("FAIL 8n1_rx_active_end got %b want 0", rx_active);
    end
  endtask

  task automatic test_parity();
    rec_t r;
    rec_t e;
    for (int k = 0; k < 2; k++) begin
      send_frame(8'h35, 2'b10, 2'b10, k[0], 1'b1, 1'b0);
      e = '{d: 8'h35, pe: k[0], fe: 1'b0};
      checks++;
      if (rec_q.size() !== 1) begin
        errors++;
        $display("FAIL 7e1_count[%0d] got %0d want 1", k, rec_q.size());
      end
      r = pop_rec();
      rec_q.delete();
      checks++;
      if (r !== e) begin
        errors++;
        $display("FAIL 7e1_frame[%0d] got d=%h pe=%b fe=%b want d=%h pe=%b fe=%b", k, r.d, r.pe, r.fe, e.d, e.pe, e.fe);
      end
    end
    send_frame(8'h1F, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0);
    e = '{d: 8'h1F, pe: 1'b0, fe: 1'b0};
    r = pop_rec();
    rec_q.delete();
    checks++;
    if (r !== e) begin
      errors++;
      $display("FAIL 5o1_frame got d=%h pe=%b fe=%b want d=%h pe=%b fe=%b", r.d, r.pe, r.fe, e.d, e.pe, e.fe);
    end
  endtask

  task automatic test_mid_reset();
    rec_t r;
    rec_t e;
    len = 2'b11;
    parity_type = 2'b00;
    drive(1'b0, 16);
    drive(1'b1, 48);
    checks++;
    if (rx_active !== 1'b1) begin
      errors++;
      $display("FAIL midrst_active_before got %b want 1", rx_active);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({data_out, data_valid, parity_err, frame_err, rx_active} !== 12'h000) begin
      errors++;
      $display("FAIL midrst_outputs got %h want 000",
               {data_out, data_valid, parity_err, frame_err, rx_active});
    end
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 4);
    rec_q.delete();
    send_frame(8'h3C, 2'b11, 2'b00, 1'b0, 1'b1, 1'b0);
    e = '{d: 8'h3C, pe: 1'b0, fe: 1'b0};
    r = pop_rec();
    rec_q.delete();
    checks++;
    if (r !== e) begin
      errors++;
      $display("FAIL midrst_next_frame got d=%h pe=%b fe=%b want d=%h pe=%b fe=%b", r.d, r.pe, r.fe, e.d, e.pe, e.fe);
    end
  endtask

  task automatic test_glitch();
    drive(1'b0, 4);
    checks++;
    if (rx_active !== 1'b1) begin
      errors++;
      $display("FAIL glitch_active_rise got %b want 1", rx_active);
    end
    drive(1'b1, 12);
    checks++;
    if (rx_active !== 1'b0) begin
      errors++;
      $display("FAIL glitch_active_fall got %b want 0", rx_active);
    end
    checks++;
    if (rec_q.size() !== 0 || data_out !== 8'h3C) begin
      errors++;
      $display("FAIL glitch_no_frame got %0d frames data=%h want 0 frames data=3c", rec_q.size(), data_out);
    end
    rec_q.delete();
  endtask

  task automatic test_break();
    rec_t r;
    rec_t e;
    len = 2'b11;
    parity_type = 2'b00;
    drive(1'b0, 16 * 10);
    e = '{d: 8'h00, pe: 1'b0, fe: 1'b1};
    checks++;
    if (rec_q.size() !== 1) begin
      errors++;
      $display("FAIL break_count got %0d want 1", rec_q.size());
    end
    r = pop_rec();
    rec_q.delete();
    checks++;
    if (r !== e) begin
      errors++;
      $display("FAIL break_frame got d=%h pe=%b fe=%b want d=%h pe=%b fe=%b", r.d, r.pe, r.fe, e.d, e.pe, e.fe);
    end
    drive(1'b0, 16 * 40);
    checks++;
    if (rec_q.size() !== 0 || rx_active !== 1'b0) begin
      errors++;
      $display("FAIL break_rearm got %0d frames active=%b want 0 frames active=0", rec_q.size(), rx_active);
    end
    rec_q.delete();
    drive(1'b1, 8);
    send_frame(8'h5A, 2'b11, 2'b00, 1'b0, 1'b1, 1'b0);
    e = '{d: 8'h5A, pe: 1'b0, fe: 1'b0};
    r = pop_rec();
    rec_q.delete();
    checks++;
    if (r !== e) begin
      errors++;
      $display("FAIL break_recover got d=%h pe=%b fe=%b want d=%h pe=%b fe=%b", r.d, r.pe, r.fe, e.d, e.pe, e.fe);
    end
  endtask

  task automatic test_random();
    rec_t r;
    rec_t e;
    logic [7:0] d;
    logic [1:0] l;
    logic [1:0] pt;
    logic       pbit;
    logic       stop;
    for (int i = 0; i < 25; i++) begin
      d    = 8'($urandom);
      l    = 2'($urandom);
      pt   = 2'($urandom);
      pbit = good_parity(d, l, pt) ^ ($urandom_range(0, 3) == 0);
      stop = ($urandom_range(0, 4) != 0);
      send_frame(d, l, pt, pbit, stop, 1'b1);
      e = model(d, l, pt, pbit, stop);
      checks++;
      if (rec_q.size() !== 1) begin
        errors++;
        $display("FAIL rand_count[%0d] got %0d want 1", i, rec_q.size());
      end
      r = pop_rec();
      rec_q.delete();
      checks++;
      if (r !== e) begin
        errors++;
        $display("FAIL rand_frame[%0d] len=%b par=%b got d=%h pe=%b fe=%b want d=%h pe=%b fe=%b",
                 i, l, pt, r.d, r.pe, r.fe, e.d, e.pe, e.fe);
      end
    end
    checks++;
    if (wide_cnt !== 0) begin
      errors++;
      $display("FAIL rand_valid_width got %0d wide pulses want 0", wide_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_mid_reset();
    test_glitch();
    test_break();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
